// File: rtl/uart_pkg.sv
// Constants shared by the UART receive, transmit and buffering blocks.
// Defaults here match the 16-entry receive FIFO at 115200 baud from a 50 MHz clock.
package uart_pkg;

    localparam int BYTE_W    = 8;
    localparam int DEPTH     = 16;
    localparam int ADDR_BITS = 4;
    localparam int CLK_FREQ  = 50_000_000;
    localparam int BAUD_RATE = 115_200;

    // Clock cycles per bit, rounded to nearest, shared with the rx/tx bit timers.
    localparam int BIT_CYCLES = (CLK_FREQ + BAUD_RATE / 2) / BAUD_RATE;

    typedef logic [BYTE_W-1:0] byte_t;

    typedef enum logic [1:0] {
        OCC_IDLE = 2'b00,
        OCC_INC  = 2'b01,
        OCC_DEC  = 2'b10,
        OCC_HOLD = 2'b11
    } occ_op_e;

    function automatic occ_op_e occ_op(input logic wr, input logic rd);
        occ_op_e op;
        unique case ({rd, wr})
            2'b01:   op = OCC_INC;
            2'b10:   op = OCC_DEC;
            2'b11:   op = OCC_HOLD;
            default: op = OCC_IDLE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Receiver-facing and host-facing signals of the receive FIFO.
// The FIFO block uses the slave modport; the host/receiver side uses master.
interface uart_rx_fifo_if
    import uart_pkg::*;
#(
    parameter int ADDR_BITS = uart_pkg::ADDR_BITS
);
    logic               enable;
    logic               rx_en;
    byte_t              rx_data;
    logic               rx_end;
    logic               rd_en;
    byte_t              rd_data;
    logic               empty;
    logic               full;
    logic [ADDR_BITS:0] count;
    logic               overflow;
    logic               ovf_clr;

    modport slave (
        input  enable, rx_data, rx_end, rd_en, ovf_clr,
        output rx_en, rd_data, empty, full, count, overflow
    );

    modport master (
        output enable, rx_data, rx_end, rd_en, ovf_clr,
        input  rx_en, rd_data, empty, full, count, overflow
    );
endinterface

// File: rtl/uart_fifo_ram.sv
// DEPTH x BYTE_W storage: synchronous write, asynchronous (show-ahead) read.
// Contents are never reset; validity is tracked by the owner's pointers.
module uart_fifo_ram
    import uart_pkg::*;
#(
    parameter int DEPTH     = uart_pkg::DEPTH,
    parameter int ADDR_BITS = uart_pkg::ADDR_BITS
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] waddr,
    input  byte_t                wdata,
    input  logic [ADDR_BITS-1:0] raddr,
    output byte_t                rdata
);
    byte_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/uart_rx_fifo.sv
// Captures each received byte on the rising edge of the receiver end flag and
// buffers it for the host with show-ahead read data, occupancy and sticky overflow.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH     = uart_pkg::DEPTH,
    parameter int ADDR_BITS = uart_pkg::ADDR_BITS
) (
    input  logic           clk,
    input  logic           rst_n,
    uart_rx_fifo_if.slave  bus
);
    localparam logic [ADDR_BITS:0] FULL_CNT = (ADDR_BITS + 1)'(DEPTH);

    logic [ADDR_BITS-1:0] wr_ptr;
    logic [ADDR_BITS-1:0] rd_ptr;
    logic [ADDR_BITS:0]   count;
    logic                 overflow;
    logic                 end_q;

    logic                 push;
    logic                 pop;
    logic                 wr_ok;
    logic                 ovf_set;
    logic                 empty;
    logic                 full;
    byte_t                head;

    logic [ADDR_BITS:0]   count_nxt;
    logic                 overflow_nxt;

    function automatic logic [ADDR_BITS:0] count_step(input logic [ADDR_BITS:0] cur,
                                                      input occ_op_e op);
        logic [ADDR_BITS:0] res;
        res = cur;
        unique case (op)
            OCC_INC: res = (cur == FULL_CNT) ? cur : cur + 1'b1;
            OCC_DEC: res = (cur == '0) ? cur : cur - 1'b1;
            default: res = cur;
        endcase
        return res;
    endfunction

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);

    // end_q resets high so a frame already ending at reset release is not taken.
    assign push    = bus.rx_end & ~end_q;
    assign pop     = bus.rd_en & ~empty;
    assign wr_ok   = push & (~full | pop);
    assign ovf_set = push & full & ~pop;

    always_comb begin
        count_nxt    = count_step(count, occ_op(wr_ok, pop));
        overflow_nxt = overflow;
        if (ovf_set) begin
            overflow_nxt = 1'b1;
        end else if (bus.ovf_clr) begin
            overflow_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            end_q    <= 1'b1;
        end else begin
            end_q    <= bus.rx_end;
            count    <= count_nxt;
            overflow <= overflow_nxt;
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // When full with a simultaneous pop, wr_ptr == rd_ptr: the old head is read
    // combinationally this cycle while the new byte lands in the same slot.
    uart_fifo_ram #(
        .DEPTH     (DEPTH),
        .ADDR_BITS (ADDR_BITS)
    ) u_ram (
        .clk   (clk),
        .we    (wr_ok),
        .waddr (wr_ptr),
        .wdata (bus.rx_data),
        .raddr (rd_ptr),
        .rdata (head)
    );

    assign bus.rx_en    = bus.enable;
    assign bus.rd_data  = empty ? '0 : head;
    assign bus.empty    = empty;
    assign bus.full     = full;
    assign bus.count    = count;
    assign bus.overflow = overflow;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: frame table plus corner-case sequences,
// with a byte queue as the expected-content model.
module tb_uart_rx_fifo;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_rx_fifo_if #(.ADDR_BITS(4)) bus ();

    uart_rx_fifo #(.DEPTH(DEPTH), .ADDR_BITS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    logic [7:0] q [$];
    logic ovf_m = 1'b0;

    typedef struct {
        logic [7:0] data;
        int         len;
        logic       en;
        int         exp_count;
        logic       exp_rx_en;
    } frame_vec_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge with rx_end low again.
    task automatic send_frame(input logic [7:0] d, input int len);
        bus.rx_data = d;
        bus.rx_end  = 1'b1;
        if (q.size() < DEPTH) q.push_back(d);
        else ovf_m = 1'b1;
        repeat (len) @(negedge clk);
        bus.rx_end = 1'b0;
        @(negedge clk);
    endtask

    task automatic pop_check(input string nm);
        if (q.size() == 0) begin
            check({nm, "_empty_rd"}, {24'h0, bus.rd_data}, 32'h0);
        end else begin
            check(nm, {24'h0, bus.rd_data}, {24'h0, q[0]});
        end
        bus.rd_en = 1'b1;
        @(negedge clk);
        bus.rd_en = 1'b0;
        if (q.size() > 0) void'(q.pop_front());
    endtask

    task automatic drain(input string nm);
        while (q.size() > 0) pop_check(nm);
        check({nm, "_empty"}, {31'h0, bus.empty}, 32'h1);
        check({nm, "_rd0"}, {24'h0, bus.rd_data}, 32'h0);
    endtask

    task automatic check_status(input string nm);
        check({nm, "_count"}, {27'h0, bus.count}, q.size());
        check({nm, "_full"}, {31'h0, bus.full}, (q.size() == DEPTH) ? 32'h1 : 32'h0);
        check({nm, "_ovf"}, {31'h0, bus.overflow}, {31'h0, ovf_m});
    endtask

    frame_vec_t tbl [3];

    initial begin
        tbl[0] = '{data: 8'h41, len: 434, en: 1'b1, exp_count: 1, exp_rx_en: 1'b1};
        tbl[1] = '{data: 8'h42, len: 434, en: 1'b0, exp_count: 2, exp_rx_en: 1'b0};
        tbl[2] = '{data: 8'h43, len: 434, en: 1'b1, exp_count: 3, exp_rx_en: 1'b1};

        bus.enable  = 1'b1;
        bus.rx_data = 8'hFF;
        bus.rx_end  = 1'b1;
        bus.rd_en   = 1'b0;
        bus.ovf_clr = 1'b0;

        // Test 1: rx_end high across reset release must not push.
        repeat (3) @(negedge clk);
        check("rst_empty", {31'h0, bus.empty}, 32'h1);
        check("rst_rd0", {24'h0, bus.rd_data}, 32'h0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("rel_empty", {31'h0, bus.empty}, 32'h1);
        check_status("rel");
        bus.rx_end = 1'b0;
        @(negedge clk);

        // Test 2: three long frames from the table; enable low mid-stream still buffers.
        for (int i = 0; i < 3; i++) begin
            bus.enable = tbl[i].en;
            @(negedge clk);
            check($sformatf("rx_en_%0d", i), {31'h0, bus.rx_en}, {31'h0, tbl[i].exp_rx_en});
            send_frame(tbl[i].data, tbl[i].len);
            check($sformatf("t2_count_%0d", i), {27'h0, bus.count}, tbl[i].exp_count);
        end
        bus.enable = 1'b1;
        drain("t2");

        // Test 3: DEPTH+1 frames, last one dropped.
        for (int i = 0; i <= DEPTH; i++) send_frame(8'h10 + 8'(i), 3);
        check_status("t3");
        drain("t3");
        bus.ovf_clr = 1'b1;
        @(negedge clk);
        bus.ovf_clr = 1'b0;
        ovf_m = 1'b0;
        check("t3_clr", {31'h0, bus.overflow}, 32'h0);

        // Test 4: full, push and pop in the same cycle.
        for (int i = 0; i < DEPTH; i++) send_frame(8'h80 + 8'(i), 2);
        check_status("t4_pre");
        check("t4_head", {24'h0, bus.rd_data}, {24'h0, q[0]});
        bus.rx_data = 8'hC3;
        bus.rx_end  = 1'b1;
        bus.rd_en   = 1'b1;
        @(negedge clk);
        bus.rd_en = 1'b0;
        void'(q.pop_front());
        q.push_back(8'hC3);
        check_status("t4_post");
        bus.rx_end = 1'b0;
        @(negedge clk);
        drain("t4");

        // Test 5: empty, push with rd_en the same cycle.
        bus.rx_data = 8'h5A;
        bus.rx_end  = 1'b1;
        bus.rd_en   = 1'b1;
        q.push_back(8'h5A);
        @(negedge clk);
        bus.rd_en = 1'b0;
        check_status("t5");
        check("t5_rd", {24'h0, bus.rd_data}, 32'h5A);
        bus.rx_end = 1'b0;
        @(negedge clk);
        drain("t5");

        // Test 6: ovf_clr loses to a coincident overflowing push.
        for (int i = 0; i <= DEPTH; i++) send_frame(8'hA0 + 8'(i), 2);
        check_status("t6_ovf");
        bus.rx_data = 8'hEE;
        bus.rx_end  = 1'b1;
        bus.ovf_clr = 1'b1;
        @(negedge clk);
        bus.ovf_clr = 1'b0;
        bus.rx_end  = 1'b0;
        check("t6_set_wins", {31'h0, bus.overflow}, 32'h1);
        bus.ovf_clr = 1'b1;
        @(negedge clk);
        bus.ovf_clr = 1'b0;
        ovf_m = 1'b0;
        check("t6_clr", {31'h0, bus.overflow}, 32'h0);
        check_status("t6_keep");
        drain("t6");

        // Pointer wrap: 3*DEPTH interleaved push/pop with a small standing backlog.
        send_frame(8'($urandom_range(0, 255)), 2);
        send_frame(8'($urandom_range(0, 255)), 2);
        for (int i = 0; i < 3 * DEPTH; i++) begin
            send_frame(8'($urandom_range(0, 255)), 1 + (i % 3));
            pop_check($sformatf("wrap_%0d", i));
        end
        check_status("wrap");
        drain("wrap");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
